warp_fetch_queue: RTL and testbench

- Parametrised, handshaked decoupling queue between warp_fetch and decode.
- Replaces the plain IF/ID register barrier with a DEPTH-entry FIFO of fetch bundles, each LANES instructions wide.
- Adds valid/ready backpressure, a branch-redirect flush and an occupancy count.
- Sits between the fetch unit output and the decode input inside the hart.

---
 rtl/warp_fetch_queue.sv | 95 +++++++++
 tb/tb_warp_fetch_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/warp_fetch_queue.sv
// Decoupling FIFO of fetch bundles between warp_fetch and decode; a push is visible at the head one cycle later.
// o_ready/o_valid come only from registered occupancy; flush and reset empty the queue, and reset takes precedence.
module warp_fetch_queue #(
    parameter int LANES = 2,
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    localparam int CW   = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [XLEN-1:0]     i_pc,
    input  logic [32*LANES-1:0] i_inst,
    input  logic [LANES-1:0]    i_compressed,
    input  logic [CW-1:0]       i_count,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [XLEN-1:0]     o_pc,
    output logic [32*LANES-1:0] o_inst,
    output logic [LANES-1:0]    o_compressed,
    output logic [CW-1:0]       o_count,
    output logic [AW:0]         o_occupancy
);

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [32*LANES-1:0] inst;
        logic [LANES-1:0]    compressed;
        logic [CW-1:0]       count;
    } bundle_t;

    bundle_t       mem [DEPTH];
    bundle_t       wr_bundle;
    bundle_t       head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occupancy;
    logic          push;
    logic          pop;

    // Full and empty are told apart by occupancy, never by pointer equality.
    assign o_ready     = (occupancy != (AW+1)'(DEPTH));
    assign o_valid     = (occupancy != '0);
    assign o_occupancy = occupancy;

    assign push = i_valid && o_ready;
    assign pop  = o_valid && i_ready;

    assign wr_bundle.pc         = i_pc;
    assign wr_bundle.inst       = i_inst;
    assign wr_bundle.compressed = i_compressed;
    assign wr_bundle.count      = i_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (i_flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + (AW+1)'(1);
                2'b01:   occupancy <= occupancy - (AW+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage is left unreset; only the pointers define what is live.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst && !i_flush) begin
            mem[wr_ptr] <= wr_bundle;
        end
    end

    // The head is forced to zero while empty so it reads all-zero after reset.
    assign head         = mem[rd_ptr];
    assign o_pc         = o_valid ? head.pc         : '0;
    assign o_inst       = o_valid ? head.inst       : '0;
    assign o_compressed = o_valid ? head.compressed : '0;
    assign o_count      = o_valid ? head.count      : '0;

endmodule

// File: tb/tb_warp_fetch_queue.sv
// Self-checking bench for warp_fetch_queue: directed table, hand-written corner sequences and random traffic.
module tb_warp_fetch_queue;

    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int CW    = 1;
    localparam int AW    = 2;

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b1;
    logic                i_flush = 1'b0;
    logic                i_valid = 1'b0;
    logic                o_ready;
    logic [XLEN-1:0]     i_pc = '0;
    logic [32*LANES-1:0] i_inst = '0;
    logic [LANES-1:0]    i_compressed = '0;
    logic [CW-1:0]       i_count = '0;
    logic                o_valid;
    logic                i_ready = 1'b0;
    logic [XLEN-1:0]     o_pc;
    logic [32*LANES-1:0] o_inst;
    logic [LANES-1:0]    o_compressed;
    logic [CW-1:0]       o_count;
    logic [AW:0]         o_occupancy;

    warp_fetch_queue #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_inst(i_inst), .i_compressed(i_compressed), .i_count(i_count),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_pc(o_pc), .o_inst(o_inst), .o_compressed(o_compressed), .o_count(o_count),
        .o_occupancy(o_occupancy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [XLEN-1:0]     pc;
        logic [32*LANES-1:0] inst;
        logic [LANES-1:0]    comp;
        logic [CW-1:0]       cnt;
    } entry_t;

    typedef struct {
        bit              v;
        bit              r;
        logic [XLEN-1:0] pc;
        bit              ev;
        bit              er;
        int              eocc;
        logic [XLEN-1:0] epc;
    } vec_t;

    entry_t mq[$];
    entry_t cur;
    bit     after_rst = 1'b1;
    int     checks = 0;
    int     failures = 0;
    vec_t   tbl[9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rs, input bit fl, input bit v, input bit r, input logic [XLEN-1:0] pc);
        i_rst        = rs;
        i_flush      = fl;
        i_valid      = v;
        i_ready      = r;
        i_pc         = pc;
        i_inst       = {pc[31:0] ^ 32'h00100093, pc[31:0] ^ 32'h00000013};
        i_compressed = pc[4:3];
        i_count      = pc[3];
        cur.pc   = i_pc;
        cur.inst = i_inst;
        cur.comp = i_compressed;
        cur.cnt  = i_count;
    endtask

    // Reference queue: an ordered list of bundles with capacity DEPTH.
    task automatic model_check();
        check("valid", o_valid, mq.size() != 0);
        check("ready", o_ready, mq.size() != DEPTH);
        check("occupancy", o_occupancy, mq.size());
        if (mq.size() != 0) begin
            check("head_pc", o_pc, mq[0].pc);
            check("head_inst", o_inst, mq[0].inst);
            check("head_comp", o_compressed, mq[0].comp);
            check("head_count", o_count, mq[0].cnt);
        end else if (after_rst) begin
            check("rst_pc", o_pc, 0);
            check("rst_inst", o_inst, 0);
            check("rst_comp", o_compressed, 0);
            check("rst_count", o_count, 0);
        end
    endtask

    task automatic step();
        bit push;
        bit pop;
        push = i_valid && (mq.size() < DEPTH);
        pop  = i_ready && (mq.size() != 0);
        @(posedge i_clk);
        #1;
        if (i_rst) begin
            mq.delete();
            after_rst = 1'b1;
        end else if (i_flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(cur);
                after_rst = 1'b0;
            end
        end
        model_check();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 64'h1000, 1'b1, 1'b1, 1, 64'h1000};
        tbl[1] = '{1'b1, 1'b0, 64'h1008, 1'b1, 1'b1, 2, 64'h1000};
        tbl[2] = '{1'b1, 1'b0, 64'h1010, 1'b1, 1'b1, 3, 64'h1000};
        tbl[3] = '{1'b1, 1'b0, 64'h1018, 1'b1, 1'b0, 4, 64'h1000};
        tbl[4] = '{1'b1, 1'b0, 64'h1020, 1'b1, 1'b0, 4, 64'h1000};
        tbl[5] = '{1'b0, 1'b1, 64'h0,    1'b1, 1'b1, 3, 64'h1008};
        tbl[6] = '{1'b0, 1'b1, 64'h0,    1'b1, 1'b1, 2, 64'h1010};
        tbl[7] = '{1'b0, 1'b1, 64'h0,    1'b1, 1'b1, 1, 64'h1018};
        tbl[8] = '{1'b0, 1'b1, 64'h0,    1'b0, 1'b1, 0, 64'h0};

        // Reset for two cycles, then idle.
        drive(1, 0, 0, 0, 0);
        step();
        step();
        drive(0, 0, 0, 0, 0);
        step();
        check("idle_valid", o_valid, 0);
        check("idle_ready", o_ready, 1);
        check("idle_occ", o_occupancy, 0);
        check("idle_inst", o_inst, 0);

        // Fill with a stalled consumer, then drain in order.
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, tbl[i].v, tbl[i].r, tbl[i].pc);
            step();
            check($sformatf("tbl%0d_valid", i), o_valid, tbl[i].ev);
            check($sformatf("tbl%0d_ready", i), o_ready, tbl[i].er);
            check($sformatf("tbl%0d_occ", i), o_occupancy, tbl[i].eocc);
            if (tbl[i].ev) check($sformatf("tbl%0d_pc", i), o_pc, tbl[i].epc);
        end

        // Streaming across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 1, 64'h4000 + 64'(8 * i));
            step();
            check("stream_occ", o_occupancy, 1);
            check("stream_pc", o_pc, 64'h4000 + 64'(8 * i));
        end
        drive(0, 0, 0, 1, 0);
        step();
        check("stream_empty", o_valid, 0);

        // Flush collides with a push and a pop at occupancy 3.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 64'h5000 + 64'(8 * i));
            step();
        end
        check("pre_flush_occ", o_occupancy, 3);
        drive(0, 1, 1, 1, 64'h2000);
        step();
        check("flush_valid", o_valid, 0);
        check("flush_ready", o_ready, 1);
        check("flush_occ", o_occupancy, 0);
        drive(0, 0, 1, 0, 64'h3000);
        step();
        check("post_flush_pc", o_pc, 64'h3000);
        check("post_flush_occ", o_occupancy, 1);
        drive(0, 0, 0, 1, 0);
        step();
        check("post_flush_empty", o_valid, 0);

        // At full: pop proceeds, offered push is refused.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0, 64'h6000 + 64'(8 * i));
            step();
        end
        drive(0, 0, 1, 1, 64'h7000);
        step();
        check("full_pop_occ", o_occupancy, 3);
        check("full_pop_pc", o_pc, 64'h6008);
        drive(0, 0, 0, 1, 0);
        step();
        check("full_drain_pc1", o_pc, 64'h6010);
        step();
        check("full_drain_pc2", o_pc, 64'h6018);
        step();
        check("full_drain_empty", o_valid, 0);

        // Reset wins over flush and over push/pop.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0, 64'h8000 + 64'(8 * i));
            step();
        end
        drive(1, 1, 1, 1, 64'h9000);
        step();
        check("rst_prec_occ", o_occupancy, 0);
        check("rst_prec_valid", o_valid, 0);
        check("rst_prec_ready", o_ready, 1);
        check("rst_prec_pc", o_pc, 0);

        // Random traffic against the reference queue.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0),
                  {$urandom, $urandom});
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
